// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between writeback and the
// exception PC-backup path (k0/$26), keeping program order via a pending FIFO.
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exc_req,
  input  logic [DATA_W-1:0] exc_data,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] byp_addr_1,
  input  logic [ADDR_W-1:0] byp_addr_2,
  output logic              byp_hit_1,
  output logic              byp_hit_2,
  output logic [DATA_W-1:0] byp_data_1,
  output logic [DATA_W-1:0] byp_data_2,
  output logic [CNT_W-1:0]  pending_count
);

  localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(26);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic              acc_wb, acc_exc, fifo_empty;
  logic              pop, issue;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;
  logic              enq_a_v, enq_b_v;
  logic [ADDR_W-1:0] enq_a_addr, enq_b_addr;
  logic [DATA_W-1:0] enq_a_data, enq_b_data;
  logic [1:0]        n_enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wb_stall      = (count == CNT_W'(DEPTH));
  assign pending_count = count;
  assign fifo_empty    = (count == '0);
  assign acc_wb        = wb_req && !wb_stall && (wb_addr != '0);
  assign acc_exc       = exc_req;
  assign n_enq         = {1'b0, enq_a_v} + {1'b0, enq_b_v};

  // Writeback is always the older of two same-cycle writes.
  always_comb begin
    pop        = 1'b0;
    issue      = 1'b0;
    iss_addr   = rf_waddr;
    iss_data   = rf_wdata;
    enq_a_v    = 1'b0;
    enq_a_addr = '0;
    enq_a_data = '0;
    enq_b_v    = 1'b0;
    enq_b_addr = '0;
    enq_b_data = '0;
    if (!fifo_empty) begin
      pop      = 1'b1;
      issue    = 1'b1;
      iss_addr = q_addr[head];
      iss_data = q_data[head];
      if (acc_wb) begin
        enq_a_v    = 1'b1;
        enq_a_addr = wb_addr;
        enq_a_data = wb_data;
        enq_b_v    = acc_exc;
        enq_b_addr = EXC_ADDR;
        enq_b_data = exc_data;
      end else begin
        enq_a_v    = acc_exc;
        enq_a_addr = EXC_ADDR;
        enq_a_data = exc_data;
      end
    end else if (acc_wb) begin
      issue      = 1'b1;
      iss_addr   = wb_addr;
      iss_data   = wb_data;
      enq_a_v    = acc_exc;
      enq_a_addr = EXC_ADDR;
      enq_a_data = exc_data;
    end else if (acc_exc) begin
      issue    = 1'b1;
      iss_addr = EXC_ADDR;
      iss_data = exc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (pop) head <= ptr_inc(head);
      if (n_enq == 2'd2) tail <= ptr_inc(ptr_inc(tail));
      else if (n_enq == 2'd1) tail <= ptr_inc(tail);
      count <= count + CNT_W'(n_enq) - CNT_W'(pop);
      rf_we <= issue;
      if (issue) begin
        rf_waddr <= iss_addr;
        rf_wdata <= iss_data;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq_a_v) begin
      q_addr[tail] <= enq_a_addr;
      q_data[tail] <= enq_a_data;
    end
    if (enq_b_v) begin
      q_addr[ptr_inc(tail)] <= enq_b_addr;
      q_data[ptr_inc(tail)] <= enq_b_data;
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit_1  = 1'b0;
    byp_hit_2  = 1'b0;
    byp_data_1 = '0;
    byp_data_2 = '0;
    if (rf_we && rf_waddr == byp_addr_1 && byp_addr_1 != '0) begin
      byp_hit_1  = 1'b1;
      byp_data_1 = rf_wdata;
    end
    if (rf_we && rf_waddr == byp_addr_2 && byp_addr_2 != '0) begin
      byp_hit_2  = 1'b1;
      byp_data_2 = rf_wdata;
    end
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count)) begin
        if (q_addr[idx] == byp_addr_1 && byp_addr_1 != '0) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = q_data[idx];
        end
        if (q_addr[idx] == byp_addr_2 && byp_addr_2 != '0) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = q_data[idx];
        end
      end
      idx = ptr_inc(idx);
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the writeback stage and the exception PC-backup path, which targets $26/k0.
- Preserves program order of writes through a small pending FIFO and raises a writeback stall when that FIFO is full.
- Provides read-bypass of pending, not-yet-committed writes so decode reads stay coherent.
- Sits between the WB stage / exception logic and the register file, and drives that file's write inputs.

Parameters:
DEPTH  4  pending-write FIFO entries; legal range 2..16
ADDR_W  5  register address width
DATA_W  32  register data width

Ports:
clk  in  1  clock, posedge
reset  in  1  asynchronous, active-high reset
wb_req  in  1  writeback write request (equivalent to RegWrite)
wb_addr  in  ADDR_W  writeback destination register
wb_data  in  DATA_W  writeback data
exc_req  in  1  exception PC-backup request; destination fixed at 26
exc_data  in  DATA_W  PC value to back up
wb_stall  out  1  writeback must hold; wb_req is ignored this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
byp_addr_1  in  ADDR_W  bypass lookup address, port 1
byp_addr_2  in  ADDR_W  bypass lookup address, port 2
byp_hit_1  out  1  port 1 address matches a pending entry
byp_hit_2  out  1  port 2 address matches a pending entry
byp_data_1  out  DATA_W  data of youngest matching entry, port 1
byp_data_2  out  DATA_W  data of youngest matching entry, port 2
pending_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async): FIFO emptied; pending_count=0; rf_we=0; rf_waddr=0; rf_wdata=0; wb_stall=0.
- Writes in flight at reset are discarded. The register file is reset concurrently.
- wb_stall = (pending_count == DEPTH). Combinational from registered count.
- Accepted writeback: wb_req & !wb_stall & wb_addr!=0. Writes to $0 are silently dropped and never enqueued.
- Accepted exception: exc_req. It is never stalled and is always accepted.
- Same-cycle ordering: the writeback write is older and the exception write is younger, so $26 ends holding exc_data.
- Write port per cycle (registered outputs, updated at posedge):
  - FIFO non-empty: head entry is popped and driven.
  - FIFO empty: the oldest accepted incoming write is driven; a younger same-cycle write is enqueued.
  - Nothing to issue: rf_we=0, with addr and data held.
- Latency: an uncontended write appears on rf_* one cycle after request. The register file commits it at the following edge.
- Queued writes drain one per cycle, in FIFO order.
- Occupancy next = count − pop + enqueued.
  - Exception accepted at count==DEPTH: pop happens the same cycle, wb is stalled, so there is no overflow.
  - count==DEPTH−1 with both requests: result is DEPTH.
  - Overflow is unreachable; the bench asserts it.
- An entry counts as pending from enqueue (or from being latched onto rf_*) until the edge at which rf_we commits it. The entry currently on rf_* is included.
- Bypass is combinational:
  - The youngest pending entry matching byp_addr_n wins. Order is: FIFO tail first, then head, then the rf_* entry.
  - Address 0 never hits.
  - On a miss, byp_data_n=0.
  - Same-cycle incoming requests are not bypassed; pipeline forwarding covers them.
- Duplicate addresses in the FIFO are legal. Writes are not coalesced.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then a single writeback wb_addr=5, data=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Following cycle rf_we=0 and pending_count=0.
- wb_req to $0 with data 0xFFFF → rf_we stays 0 and no pending entry is created.
- Same cycle: wb_addr=26 with 0xAAAA, plus exc_data=0x00400010 → rf_* carries 26/0xAAAA, then 26/0x00400010. byp_addr_1=26 returns 0x00400010 while that entry is pending.
- Back-to-back dual requests (wb_addr=1..5 with exc_req every cycle) → pending_count reaches 4 and wb_stall=1. The stalled wb is held and accepted after drain. Final write order matches request order.
- Queue two writes to $8 (0x11, then 0x22) → byp_hit_1=1 with byp_data_1=0x22 until both commit, then byp_hit_1=0.
- Assert reset asynchronously with 3 entries pending → pending_count=0, rf_we=0 immediately. No further writes issue after reset release.
